// File: rtl/sequence_control_pkg.sv
// ---------------------------------------------------------------------------
// sequence_control_pkg
// Shared definitions for the sequence control slice of the basic computer.
//   - opcode_t  : decoded IR[14:12] values (AND .. IO-class)
//   - SC_WIDTH  : width of the sequence counter
//   - SC_T2     : counter value at which the instruction is decoded
//   - onehot()  : 3-to-8 one-hot decoder, also used by the bus-select logic
// ---------------------------------------------------------------------------
package sequence_control_pkg;

   localparam int SC_WIDTH = 3;

   typedef enum logic [2:0] {
      OP_AND = 3'd0,
      OP_ADD = 3'd1,
      OP_LDA = 3'd2,
      OP_STA = 3'd3,
      OP_BUN = 3'd4,
      OP_BSA = 3'd5,
      OP_ISZ = 3'd6,
      OP_IO  = 3'd7
   } opcode_t;

   localparam logic [SC_WIDTH-1:0] SC_T2 = 3'd2;

   // Turns a 3-bit index into the matching one-hot byte, e.g. 5 -> 8'h20.
   function automatic logic [7:0] onehot(input logic [2:0] sel);
      onehot = 8'h01 << sel;
   endfunction

endpackage

// File: rtl/sequence_control_if.sv
// ---------------------------------------------------------------------------
// sequence_control_if
// Groups the control inputs and timing/decode outputs of sequence_control.
//   master : drives start/hlt/sc_clr/ir_i/ir_op/ien_set/ien_clr/fgi/fgo,
//            observes t/d/i_flag/r_flag/ien/s_run
//   slave  : the sequence_control side (mirror of master)
// ---------------------------------------------------------------------------
interface sequence_control_if;
   import sequence_control_pkg::*;

   logic                start;
   logic                hlt;
   logic                sc_clr;
   logic                ir_i;
   logic [2:0]          ir_op;
   logic                ien_set;
   logic                ien_clr;
   logic                fgi;
   logic                fgo;

   logic [7:0]          t;
   logic [7:0]          d;
   logic                i_flag;
   logic                r_flag;
   logic                ien;
   logic                s_run;

   modport master (
      output start, hlt, sc_clr, ir_i, ir_op, ien_set, ien_clr, fgi, fgo,
      input  t, d, i_flag, r_flag, ien, s_run
   );

   modport slave (
      input  start, hlt, sc_clr, ir_i, ir_op, ien_set, ien_clr, fgi, fgo,
      output t, d, i_flag, r_flag, ien, s_run
   );

endinterface

// File: rtl/sequence_control_seq_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
// 3-bit sequence counter SC with clear, increment and hold.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (count -> 0)
//   clr    : force count to 0 at the next edge (wins over inc)
//   inc    : advance count by one, wrapping 7 -> 0
//   count  : current counter value
// ---------------------------------------------------------------------------
module seq_counter
   import sequence_control_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                inc,
   output logic [SC_WIDTH-1:0] count
);

   // Clear has priority over increment; with neither asserted the value holds.
   // Wrap-around from 7 to 0 falls out of the natural 3-bit overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + SC_WIDTH'(1);
      end
   end

endmodule

// File: rtl/sequence_control.sv
// ---------------------------------------------------------------------------
// sequence_control
// Timing and control sequencer of the basic computer: sequence counter SC,
// run flag S, opcode decode D0..D7, indirect bit I, interrupt flip-flop R and
// interrupt enable IEN.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : sequence_control_if.slave
//            in  start, hlt, sc_clr, ir_i, ir_op[2:0], ien_set, ien_clr, fgi, fgo
//            out t[7:0], d[7:0], i_flag, r_flag, ien, s_run
// Configuration macro: INTERRUPT_CYCLE_EN
//   defined   - interrupt request, interrupt cycle and IEN are active
//   undefined - R and IEN stay 0; fgi, fgo, ien_set, ien_clr are ignored
// All outputs come straight from registers or from a decode of registers.
// ---------------------------------------------------------------------------
module sequence_control
   import sequence_control_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   sequence_control_if.slave  bus
);

   logic [SC_WIDTH-1:0] sc;
   logic                sRun;
   logic                rFlag;
   logic                ienFlag;
   logic                iFlag;
   logic [7:0]          dReg;

   logic                scClr;
   logic                scInc;
   logic                intrEnd;
   logic                intrRequest;
   logic                decodeNow;
   logic                sNext;
   logic                rNext;
   logic                ienNext;

`ifndef INTERRUPT_CYCLE_EN
   logic                unusedIntrInputs;
   assign unusedIntrInputs = ^{bus.fgi, bus.fgo, bus.ien_set, bus.ien_clr};
`endif

   seq_counter u_seq_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (scClr),
      .inc   (scInc),
      .count (sc)
   );

   // Next-state decisions for the run flag, the counter controls, the
   // interrupt flip-flop and the interrupt enable.
   // The interrupt cycle ends at R.T2: R and IEN drop and SC restarts at 0,
   // which takes precedence over ien_set and sc_clr in that cycle.
   // An interrupt request is raised only once the fetch/decode steps
   // (T0..T2) are over, and may coincide with sc_clr so the next T0 already
   // runs as an interrupt cycle.
   // sc_clr is only honoured during an instruction's execute phase (SC >= 3,
   // R = 0); hlt clears S and SC together and blocks a simultaneous start.
   always_comb begin
      intrEnd     = 1'b0;
      intrRequest = 1'b0;
      rNext       = 1'b0;
      ienNext     = 1'b0;
      scClr       = 1'b0;
      scInc       = sRun;
      sNext       = sRun;
      decodeNow   = sRun && !rFlag && (sc == SC_T2);

`ifdef INTERRUPT_CYCLE_EN
      intrEnd     = sRun && rFlag && (sc == SC_T2);
      intrRequest = sRun && (sc > SC_T2) && ienFlag && (bus.fgi || bus.fgo);

      rNext = rFlag;
      if (intrEnd) begin
         rNext = 1'b0;
      end else if (intrRequest) begin
         rNext = 1'b1;
      end

      ienNext = ienFlag;
      if (intrEnd || bus.ien_clr) begin
         ienNext = 1'b0;
      end else if (bus.ien_set) begin
         ienNext = 1'b1;
      end
`endif

      if (sRun) begin
         scClr = bus.hlt || intrEnd || (!rFlag && bus.sc_clr && (sc > SC_T2));
      end else begin
         scClr = bus.start && !bus.hlt;
      end

      if (bus.hlt) begin
         sNext = 1'b0;
      end else if (bus.start) begin
         sNext = 1'b1;
      end
   end

   // Flag and decode registers. The opcode and indirect bit are captured at
   // the T2 edge of a normal (non-interrupt) cycle and held otherwise, so D
   // keeps its value across an interrupt cycle and while halted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sRun    <= 1'b0;
         rFlag   <= 1'b0;
         ienFlag <= 1'b0;
         iFlag   <= 1'b0;
         dReg    <= 8'h00;
      end else begin
         sRun    <= sNext;
         rFlag   <= rNext;
         ienFlag <= ienNext;
         if (decodeNow) begin
            dReg  <= onehot(bus.ir_op);
            iFlag <= bus.ir_i;
         end
      end
   end

   // Timing signals are only live while the computer is running.
   assign bus.t      = sRun ? onehot(sc) : 8'h00;
   assign bus.d      = dReg;
   assign bus.i_flag = iFlag;
   assign bus.r_flag = rFlag;
   assign bus.ien    = ienFlag;
   assign bus.s_run  = sRun;

endmodule

// File: tb/tb_sequence_control.sv
// ---------------------------------------------------------------------------
// tb_sequence_control
// Directed scenarios followed by random stimulus, each cycle compared with a
// behavioural model of the sequencer (step number, run/interrupt flags,
// latched opcode). Interrupt expectations follow INTERRUPT_CYCLE_EN.
// ---------------------------------------------------------------------------
module tb_sequence_control;
   import sequence_control_pkg::*;

`ifdef INTERRUPT_CYCLE_EN
   localparam bit INTR_BUILD = 1'b1;
`else
   localparam bit INTR_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   sequence_control_if bus ();

   sequence_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;

   bit mRun;
   bit mIntr;
   bit mIen;
   bit mDecoded;
   bit mInd;
   int mStep;
   int mOp;

   logic       curI;
   logic [2:0] curOp;

   // One compare: counts it, and reports tag/observed/expected on mismatch.
   task automatic checkValue(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
      end
   endtask

   // Advances the reference model by one clock using the inputs present at
   // the edge. Works in terms of "which step of the instruction are we in"
   // and "are we servicing an interrupt".
   task automatic modelStep();
      bit oldRun  = mRun;
      bit oldIntr = mIntr;
      bit oldIen  = mIen;
      int oldStep = mStep;
      bit intrEnd;
      bit intrReq;
      if (!rst_n) begin
         mRun = 0; mIntr = 0; mIen = 0; mDecoded = 0; mInd = 0; mStep = 0; mOp = 0;
         return;
      end
      intrEnd = INTR_BUILD && oldRun && oldIntr && (oldStep == 2);
      intrReq = INTR_BUILD && oldRun && (oldStep >= 3) && oldIen && (bus.fgi || bus.fgo);
      if (INTR_BUILD) begin
         if (intrEnd || bus.ien_clr) mIen = 0;
         else if (bus.ien_set) mIen = 1;
      end
      if (oldRun && !oldIntr && oldStep == 2) begin
         mDecoded = 1;
         mOp      = int'(bus.ir_op);
         mInd     = bus.ir_i;
      end
      if (oldRun) begin
         if (bus.hlt) begin
            mRun  = 0;
            mStep = 0;
         end else if (intrEnd) begin
            mStep = 0;
         end else if (!oldIntr && bus.sc_clr && oldStep >= 3) begin
            mStep = 0;
         end else begin
            mStep = (oldStep + 1) % 8;
         end
      end else if (bus.start && !bus.hlt) begin
         mRun  = 1;
         mStep = 0;
      end
      if (intrEnd) mIntr = 0;
      else if (intrReq) mIntr = 1;
   endtask

   // Compares every output with the model's present state.
   task automatic checkOutput(input string tag);
      logic [7:0] expT;
      logic [7:0] expD;
      expT = mRun ? 8'(1 << mStep) : 8'h00;
      expD = mDecoded ? 8'(1 << mOp) : 8'h00;
      checkValue({tag, "/t"}, bus.t, expT);
      checkValue({tag, "/d"}, bus.d, expD);
      checkValue({tag, "/i_flag"}, {7'b0, bus.i_flag}, {7'b0, mInd});
      checkValue({tag, "/r_flag"}, {7'b0, bus.r_flag}, {7'b0, mIntr});
      checkValue({tag, "/ien"}, {7'b0, bus.ien}, {7'b0, mIen});
      checkValue({tag, "/s_run"}, {7'b0, bus.s_run}, {7'b0, mRun});
   endtask

   // Drives one cycle of inputs, clocks, advances the model and checks.
   task automatic applyStimulus(input string tag, input logic rstIn,
                                input logic startIn, input logic hltIn,
                                input logic scClrIn, input logic irIIn,
                                input logic [2:0] irOpIn, input logic ienSetIn,
                                input logic ienClrIn, input logic fgiIn,
                                input logic fgoIn);
      rst_n       = rstIn;
      bus.start   = startIn;
      bus.hlt     = hltIn;
      bus.sc_clr  = scClrIn;
      bus.ir_i    = irIIn;
      bus.ir_op   = irOpIn;
      bus.ien_set = ienSetIn;
      bus.ien_clr = ienClrIn;
      bus.fgi     = fgiIn;
      bus.fgo     = fgoIn;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   task automatic applyIdle(input string tag);
      applyStimulus(tag, 1, 0, 0, 0, curI, curOp, 0, 0, 0, 0);
   endtask

   initial begin
      curI  = 1'b0;
      curOp = OP_AND;

      // Reset, then start: T0..T3 on successive cycles.
      applyStimulus("reset0", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
      applyStimulus("reset1", 0, 1, 0, 1, 1, 3'd7, 1, 0, 1, 1);
      checkValue("reset t", bus.t, 8'h00);
      applyStimulus("start", 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
      checkValue("start T0", bus.t, 8'h01);
      applyIdle("T1");
      checkValue("seq T1", bus.t, 8'h02);
      applyIdle("T2");
      checkValue("seq T2", bus.t, 8'h04);
      applyIdle("T3");
      checkValue("seq T3", bus.t, 8'h08);
      for (int k = 0; k < 4; k++) applyIdle("run");
      checkValue("reach T7", bus.t, 8'h80);
      applyIdle("wrap");
      checkValue("wrap T7->T0", bus.t, 8'h01);

      // Fetch/decode of BSA indirect, then end of instruction at T5.
      applyIdle("fd T1");
      applyIdle("fd T2");
      applyStimulus("decode", 1, 0, 0, 0, 1, OP_BSA, 0, 0, 0, 0);
      checkValue("decode d", bus.d, 8'h20);
      checkValue("decode i", {7'b0, bus.i_flag}, 8'h01);
      curI  = 1'b1;
      curOp = OP_BSA;
      applyIdle("fd T4");
      applyIdle("fd T5");
      applyStimulus("sc_clr T5", 1, 0, 0, 1, curI, curOp, 0, 0, 0, 0);
      checkValue("sc_clr T5 t", bus.t, 8'h01);

      // Interrupt: enable, request at T3 together with end of instruction.
      applyStimulus("ien_set", 1, 0, 0, 0, curI, curOp, 1, 0, 0, 0);
      applyIdle("int T2");
      applyIdle("int T3");
      applyStimulus("fgi+clr", 1, 0, 0, 1, curI, curOp, 0, 0, 1, 0);
      checkValue("int T0 t", bus.t, 8'h01);
      applyIdle("int R.T1");
      applyIdle("int R.T2");
      applyIdle("int end");
`ifdef INTERRUPT_CYCLE_EN
      checkValue("int end t", bus.t, 8'h01);
      checkValue("int end r", {7'b0, bus.r_flag}, 8'h00);
      checkValue("int end ien", {7'b0, bus.ien}, 8'h00);
`else
      checkValue("noint t", bus.t, 8'h08);
      checkValue("noint r", {7'b0, bus.r_flag}, 8'h00);
`endif
      checkValue("int end d", bus.d, 8'h20);

      // Halt at T4 together with start, then restart.
      for (int k = 0; k < 16 && mStep != 4; k++) applyIdle("to T4");
      checkValue("at T4", bus.t, 8'h10);
      applyStimulus("hlt+start", 1, 1, 1, 0, curI, curOp, 0, 0, 0, 0);
      checkValue("halt s_run", {7'b0, bus.s_run}, 8'h00);
      checkValue("halt t", bus.t, 8'h00);
      applyIdle("halted");
      applyStimulus("restart", 1, 1, 0, 0, curI, curOp, 0, 0, 0, 0);
      checkValue("restart t", bus.t, 8'h01);

      // Simultaneous and ignored events.
      applyStimulus("ien both", 1, 0, 0, 0, curI, curOp, 1, 1, 0, 0);
      checkValue("ien both", {7'b0, bus.ien}, 8'h00);
      applyStimulus("sc_clr T1", 1, 0, 0, 1, curI, curOp, 0, 0, 0, 0);
      checkValue("sc_clr T1 ignored", bus.t, 8'h04);
      for (int k = 0; k < 5; k++) applyIdle("to T7");
      applyIdle("wrap2");
      checkValue("wrap2 t", bus.t, 8'h01);

      // Reset in the middle of an interrupt cycle.
      applyStimulus("ien_set2", 1, 0, 0, 0, curI, curOp, 1, 0, 0, 0);
      applyIdle("r T2");
      applyIdle("r T3");
      applyStimulus("fgi+clr2", 1, 0, 0, 1, curI, curOp, 0, 0, 1, 0);
      applyIdle("r R.T1");
`ifdef INTERRUPT_CYCLE_EN
      checkValue("R.T1 r", {7'b0, bus.r_flag}, 8'h01);
`else
      checkValue("noint fgi r", {7'b0, bus.r_flag}, 8'h00);
`endif
      applyStimulus("mid reset", 0, 0, 0, 0, curI, curOp, 0, 0, 0, 0);
      checkValue("mid reset t", bus.t, 8'h00);
      checkValue("mid reset d", bus.d, 8'h00);
      checkValue("mid reset i", {7'b0, bus.i_flag}, 8'h00);
      checkValue("mid reset r", {7'b0, bus.r_flag}, 8'h00);
      checkValue("mid reset ien", {7'b0, bus.ien}, 8'h00);
      checkValue("mid reset s", {7'b0, bus.s_run}, 8'h00);
      applyIdle("post reset");

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         applyStimulus("rand",
                       ($urandom_range(63) != 0),
                       ($urandom_range(7) == 0),
                       ($urandom_range(31) == 0),
                       ($urandom_range(3) == 0),
                       1'($urandom_range(1)),
                       3'($urandom_range(7)),
                       ($urandom_range(7) == 0),
                       ($urandom_range(15) == 0),
                       ($urandom_range(7) == 0),
                       ($urandom_range(7) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
